// File: rtl/if_id_fifo.sv
// if_id_fifo: DEPTH-entry {pc, inst} FIFO between the fetch and decode stages, with flush.
// Latency: 1 cycle from a push to out_valid. There is no fall-through path.
// Backpressure: in_ready depends only on occupancy (count != DEPTH) and never on out_ready.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   flush               discards every entry (branch or trap redirect)
//   in_valid/in_ready   fetch-side handshake, carrying in_pc and in_inst
//   out_valid/out_ready decode-side handshake, presenting out_pc and out_inst from the head entry
//   count               number of occupied entries
//
// DEPTH must be a power of two and at least 2, so that the pointers wrap naturally.
module if_id_fifo #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PC_W-1:0]              in_pc,
  input  logic [INST_W-1:0]            in_inst,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W-1:0]              out_pc,
  output logic [INST_W-1:0]            out_inst,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              push;
  logic              pop;

  // Both handshakes come from registered occupancy only. This keeps every
  // input-to-output path registered.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);

  // A flush cycle neither accepts nor consumes an entry.
  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  assign out_pc   = mem[rd_ptr].pc;
  assign out_inst = mem[rd_ptr].inst;
  assign count    = count_q;

  // Control state. Reset takes priority over flush, and both empty the FIFO.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The storage array is deliberately not reset. Entries become meaningful only once count covers them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: in_pc, inst: in_inst};
  end

  // Occupancy must stay within [0, DEPTH].
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= FULL_CNT);
      assert (!(push && count_q == FULL_CNT));
      assert (!(pop && count_q == '0));
    end
  end

endmodule

// File: tb/tb_if_id_fifo.sv
// tb_if_id_fifo: directed and random stimulus on a DEPTH=4 if_id_fifo, checked against a queue model.
// The model updates once per clock edge. Checks happen 1 time unit after the edge.
module tb_if_id_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
  logic [2:0]  count;

  always #5 clk = ~clk;

  if_id_fifo #(.PC_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .count(count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];       // reference contents, with the head at index 0
  logic [31:0] popped[$];  // pcs that decode actually consumed
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    chk("count", 64'(count), 64'(q.size()));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
    if (q.size() != 0) begin
      chk("out_pc", 64'(out_pc), 64'(q[0].pc));
      chk("out_inst", 64'(out_inst), 64'(q[0].inst));
    end
  endtask

  // Drive one cycle of inputs, advance the clock, update the model, then compare.
  task automatic cyc(input logic r, input logic f, input logic iv,
                     input logic [31:0] pc, input logic [31:0] inst, input logic ordy);
    bit mpush, mpop;
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
    mpush = iv && (q.size() != DEPTH) && !f;
    mpop  = ordy && (q.size() != 0) && !f;
    if (mpop && !r) popped.push_back(out_pc);
    @(posedge clk);
    #1;
    if (r || f) q.delete();
    else begin
      if (mpop)  void'(q.pop_front());
      if (mpush) q.push_back('{pc, inst});
    end
    compare_model();
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ordy);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_inst = '0;

    // Reset, then 5 idle cycles.
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      chk("idle_count", 64'(count), 64'd0);
      chk("idle_in_ready", 64'(in_ready), 64'd1);
    end

    // A single push appears one cycle later and holds while out_ready=0.
    cyc(1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0013, 1'b0);
    chk("single_vld", 64'(out_valid), 64'd1);
    chk("single_pc", 64'(out_pc), 64'h8000_0000);
    chk("single_inst", 64'(out_inst), 64'h0000_0013);
    chk("single_count", 64'(count), 64'd1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk("hold_pc", 64'(out_pc), 64'h8000_0000);
    end
    idle(1'b1);
    chk("single_drained", 64'(out_valid), 64'd0);

    // Fill to DEPTH. A fifth push is refused. Then drain in order.
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b0, 1'b1, 32'h8000_0000 + 32'(4*i), 32'h100 + 32'(i), 1'b0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    cyc(1'b0, 1'b0, 1'b1, 32'h8000_0010, 32'h104, 1'b0);
    chk("refused_count", 64'(count), 64'd4);
    popped.delete();
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("drain_n", 64'(popped.size()), 64'd4);
    for (int i = 0; i < 4 && i < popped.size(); i++)
      chk("drain_order", 64'(popped[i]), 64'h8000_0000 + 64'(4*i));
    chk("drain_count", 64'(count), 64'd0);

    // Stream for 20 cycles. The output must equal the input delayed by one cycle, across pointer wrap.
    popped.delete();
    for (int i = 0; i < 20; i++)
      cyc(1'b0, 1'b0, 1'b1, 32'h8000_1000 + 32'(4*i), 32'(i), 1'b1);
    chk("stream_count", 64'(count), 64'd1);
    chk("stream_n", 64'(popped.size()), 64'd19);
    for (int i = 0; i < popped.size(); i++)
      chk("stream_seq", 64'(popped[i]), 64'h8000_1000 + 64'(4*i));
    idle(1'b1);

    // Flush with count=3 and a simultaneous push. The flushed push never emerges.
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b1, 32'h8000_0020 + 32'(4*i), 32'h55, 1'b0);
    chk("pre_flush_count", 64'(count), 64'd3);
    cyc(1'b0, 1'b1, 1'b1, 32'h8000_0100, 32'h66, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_vld", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    popped.delete();
    cyc(1'b0, 1'b0, 1'b1, 32'h8000_0200, 32'h77, 1'b0);
    chk("post_flush_pc", 64'(out_pc), 64'h8000_0200);
    idle(1'b1);
    chk("post_flush_n", 64'(popped.size()), 64'd1);
    if (popped.size() != 0) chk("post_flush_popped", 64'(popped[0]), 64'h8000_0200);

    // Reset with count=2 during a simultaneous push and pop.
    cyc(1'b0, 1'b0, 1'b1, 32'h8000_0300, 32'h1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h8000_0304, 32'h2, 1'b0);
    chk("pre_rst_count", 64'(count), 64'd2);
    cyc(1'b1, 1'b0, 1'b1, 32'h8000_0308, 32'h3, 1'b1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Random traffic with occasional flushes and resets.
    for (int i = 0; i < 400; i++)
      cyc(1'b0 | ($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_fifo.md
Name: if_id_fifo

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register. A DEPTH-entry valid/ready FIFO carries {pc, inst} pairs from fetch to decode.
- Decouples fetch from decode stalls and adds a flush input, so a taken branch or trap redirect can discard every in-flight instruction.
- No combinational path from any input to any output, so it breaks timing between the IF and ID stages.

Parameters:
PC_W, 32, width of the pc field
INST_W, 32, width of the instruction field
DEPTH, 2, entry count; power of two, minimum 2

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  discard all entries (branch/trap redirect)
in_valid  input  1  fetch offers an entry
in_ready  output  1  FIFO can accept an entry this cycle
in_pc  input  PC_W  pc of offered entry
in_inst  input  INST_W  instruction of offered entry
out_valid  output  1  head entry is valid
out_ready  input  1  decode consumes the head entry
out_pc  output  PC_W  pc of head entry
out_inst  output  INST_W  instruction of head entry
count  output  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries.
  - wr_ptr and rd_ptr are each $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Occupancy is held in count.
- Handshakes:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
- Signal derivation:
  - in_ready = (count != DEPTH). It depends only on registered state, never on out_ready.
  - out_valid = (count != 0).
  - out_pc and out_inst are driven from the entry at rd_ptr.
- Latency:
  - An entry pushed in cycle N is visible on out_* with out_valid=1 in cycle N+1.
  - Minimum latency is 1 cycle; there is no fall-through.
- Throughput: one push and one pop per cycle are sustained when 0 < count < DEPTH.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Full (count==DEPTH):
  - in_ready=0, even if out_ready=1 in the same cycle.
  - A pop frees a slot, and in_ready rises the next cycle.
- Empty (count==0):
  - out_valid=0.
  - out_pc and out_inst hold stale data; the bench must not check them.
- Data stability: while out_valid=1 and out_ready=0, out_pc and out_inst must hold stable.
- Data on in_*: in_pc and in_inst are ignored when push=0.
- Flush (checked with priority below rst):
  - Next cycle: count=0, rd_ptr=wr_ptr=0, out_valid=0, in_ready=1.
  - A push offered in the flush cycle is dropped.
  - A pop in the flush cycle is not counted; decode must also ignore it.
- Reset:
  - Next cycle: count=0, pointers 0, out_valid=0, in_ready=1.
  - Storage contents are not reset.
  - Reset in mid-operation discards all entries, like flush.
- Counter arithmetic:
  - count += push - pop.
  - count never exceeds DEPTH or goes below 0; assert this in simulation.

Test Plan:
- Reset, then idle → count=0, out_valid=0, in_ready=1 for 5 cycles.
- Single push pc=0x80000000, inst=0x00000013 in cycle 1, out_ready=0 → cycle 2: out_valid=1, out_pc=0x80000000, out_inst=0x00000013, count=1; outputs held stable until out_ready=1, then out_valid=0 the next cycle.
- DEPTH=4, push pcs 0x80000000, +4, +8, +C with out_ready=0 → count=4, in_ready=0. A fifth push of 0x80000010 is refused. Popping 4 times returns pcs in order 0x80000000..0x8000000C, and count returns to 0.
- Streaming with in_valid=1 and out_ready=1 for 20 cycles, pcs incrementing by 4 → count settles at 1. Output pc sequence equals input delayed 1 cycle, with no drops or duplicates across pointer wrap.
- With count=3, assert flush in the same cycle as a push of pc=0x80000100 → next cycle count=0, out_valid=0, in_ready=1. The next push of 0x80000200 appears at the output, and 0x80000100 never appears.
- With count=2, assert rst in the same cycle as push and pop → next cycle count=0, out_valid=0, in_ready=1.
